// File: rtl/video_timing_pkg.sv
// Shared types and default 640x480@60 timing constants for the video raster sequencer.
package video_timing_pkg;

  localparam int unsigned COUNT_W = 11;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam logic        DEF_SYNC_POL = 1'b0;

  // Region of one raster axis, in the order the counter walks through them.
  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FRONT  = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BACK   = 2'd3
  } region_e;

endpackage

// File: rtl/video_timing_ctrl_axis_timing.sv
// One raster axis: position counter plus region FSM. Used once for the
// horizontal axis (stepped every enabled pixel) and once for the vertical
// axis (stepped by the horizontal wrap).
module axis_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic               pixelclk,
  input  logic               rst,
  input  logic               step,
  output logic [COUNT_W-1:0] cnt,
  output region_e            region,
  output logic               wrap
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0 || TOTAL > 2047) begin : g_param_check
    $error("axis_timing: region lengths must be non-zero and total must fit in 11 bits");
  end

  // Last count of each region; the region FSM leaves a region on its last count.
  localparam logic [COUNT_W-1:0] ACTIVE_END = COUNT_W'(ACTIVE - 1);
  localparam logic [COUNT_W-1:0] FRONT_END  = COUNT_W'(ACTIVE + FP - 1);
  localparam logic [COUNT_W-1:0] SYNC_END   = COUNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);

  logic [COUNT_W-1:0] cnt_q, cnt_d;
  region_e            region_q, region_d;

  // Counter and region state register.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      cnt_q    <= '0;
      region_q <= REG_ACTIVE;
    end else begin
      cnt_q    <= cnt_d;
      region_q <= region_d;
    end
  end

  // Next count and region; the position within the axis doubles as the region cycle counter.
  always_comb begin
    cnt_d    = cnt_q;
    region_d = region_q;
    wrap     = 1'b0;
    if (step) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
      unique case (region_q)
        REG_ACTIVE: if (cnt_q == ACTIVE_END) region_d = REG_FRONT;
        REG_FRONT:  if (cnt_q == FRONT_END)  region_d = REG_SYNC;
        REG_SYNC:   if (cnt_q == SYNC_END)   region_d = REG_BACK;
        REG_BACK:   if (cnt_q == LAST)       region_d = REG_ACTIVE;
        default:                             region_d = REG_ACTIVE;
      endcase
    end
  end

  assign cnt    = cnt_q;
  assign region = region_q;

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer for the TMDS colour channels: blanking, hsync (c0),
// vsync (c1), active-area coordinates and line/frame strobes. All outputs
// are registered and reflect the counter state of the previous cycle.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = DEF_SYNC_POL
) (
  input  logic               pixelclk,
  input  logic               rst,
  input  logic               en,
  output logic               blanking,
  output logic               c0,
  output logic               c1,
  output logic [COUNT_W-1:0] x,
  output logic [COUNT_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  logic [COUNT_W-1:0] h_cnt, v_cnt;
  region_e            h_region, v_region;
  logic               h_wrap;
  logic               v_wrap_unused;

  axis_timing #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .pixelclk (pixelclk),
    .rst      (rst),
    .step     (en),
    .cnt      (h_cnt),
    .region   (h_region),
    .wrap     (h_wrap)
  );

  // The vertical axis advances once per line, on the horizontal wrap.
  axis_timing #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .pixelclk (pixelclk),
    .rst      (rst),
    .step     (h_wrap),
    .cnt      (v_cnt),
    .region   (v_region),
    .wrap     (v_wrap_unused)
  );

  logic               blanking_q, blanking_d;
  logic               c0_q, c0_d;
  logic               c1_q, c1_d;
  logic [COUNT_W-1:0] x_q, x_d;
  logic [COUNT_W-1:0] y_q, y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  // Decode the current counter state into the per-pixel control values.
  always_comb begin
    blanking_d    = !(h_region == REG_ACTIVE && v_region == REG_ACTIVE);
    c0_d          = (h_region == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
    c1_d          = (v_region == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
    x_d           = (h_region == REG_ACTIVE) ? h_cnt : '0;
    y_d           = (v_region == REG_ACTIVE) ? v_cnt : '0;
    line_start_d  = (h_cnt == '0);
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Output registers: load on enabled cycles; while paused, levels hold and strobes drop
  // so a pause never stretches a line/frame pulse.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      blanking_q    <= 1'b1;
      c0_q          <= ~SYNC_POL;
      c1_q          <= ~SYNC_POL;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (en) begin
      blanking_q    <= blanking_d;
      c0_q          <= c0_d;
      c1_q          <= c1_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign blanking    = blanking_q;
  assign c0          = c0_q;
  assign c1          = c1_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl. Three instances share clock, rst and en:
//   d: default 640x480 mode (line-level behaviour),
//   m: default horizontal, short vertical 4/1/2/1 (frame-level behaviour in 6400 cycles),
//   s: SYNC_POL=1, H 4/1/2/1, V 3/1/1/1.
// Sample index i after a run start is the output reflecting logical pixel i of the frame.
module tb_video_timing_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic        d_blank, d_c0, d_c1, d_ls, d_fs;
  logic [10:0] d_x, d_y;
  logic        m_blank, m_c0, m_c1, m_ls, m_fs;
  logic [10:0] m_x, m_y;
  logic        s_blank, s_c0, s_c1, s_ls, s_fs;
  logic [10:0] s_x, s_y;

  video_timing_ctrl dut_d (
    .pixelclk (clk), .rst (rst), .en (en),
    .blanking (d_blank), .c0 (d_c0), .c1 (d_c1), .x (d_x), .y (d_y),
    .line_start (d_ls), .frame_start (d_fs)
  );

  video_timing_ctrl #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_m (
    .pixelclk (clk), .rst (rst), .en (en),
    .blanking (m_blank), .c0 (m_c0), .c1 (m_c1), .x (m_x), .y (m_y),
    .line_start (m_ls), .frame_start (m_fs)
  );

  video_timing_ctrl #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                      .SYNC_POL(1'b1)) dut_s (
    .pixelclk (clk), .rst (rst), .en (en),
    .blanking (s_blank), .c0 (s_c0), .c1 (s_c1), .x (s_x), .y (s_y),
    .line_start (s_ls), .frame_start (s_fs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset two cycles with en=1, release; returns on sample 0 (output for pixel (0,0)).
  task automatic start_run();
    rst = 1'b1;
    en  = 1'b1;
    step_n(2);
    rst = 1'b0;
    step_n(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    step_n(4);
    n_cmp++;
    if ({d_blank, d_c0, d_c1, d_ls, d_fs} !== 5'b11100) begin
      n_bad++;
      $display("FAIL reset_ctrl: got b/c0/c1/ls/fs=%b want 11100", {d_blank, d_c0, d_c1, d_ls, d_fs});
    end
    n_cmp++;
    if (d_x !== 11'd0 || d_y !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", d_x, d_y);
    end
    rst = 1'b0;
    step_n(1);
    n_cmp++;
    if ({d_blank, d_c0, d_c1, d_ls, d_fs} !== 5'b01111 || d_x !== 11'd0 || d_y !== 11'd0) begin
      n_bad++;
      $display("FAIL first_pixel: got b/c0/c1/ls/fs=%b x=%0d y=%0d want 01111 0 0",
               {d_blank, d_c0, d_c1, d_ls, d_fs}, d_x, d_y);
    end
  endtask

  task automatic test_line();
    int blank_rise = -1;
    int c0_first   = -1;
    int c0_low     = 0;
    int ls_prev    = -1;
    int ls_last    = -1;
    int xy_bad     = 0;
    int h, v;
    start_run();
    for (int i = 0; i <= 1600; i++) begin
      h = i % 800;
      v = i / 800;
      if (i < 800) begin
        if (d_blank === 1'b1 && blank_rise < 0) blank_rise = i;
        if (d_c0 === 1'b0) begin
          c0_low++;
          if (c0_first < 0) c0_first = i;
        end
      end
      if (d_ls === 1'b1) begin
        ls_prev = ls_last;
        ls_last = i;
      end
      if (d_x !== ((h < 640) ? 11'(h) : 11'd0) || d_y !== 11'(v)) xy_bad++;
      if (i < 1600) step_n(1);
    end
    n_cmp++;
    if (blank_rise !== 640) begin
      n_bad++;
      $display("FAIL line_blank_rise: got %0d want 640", blank_rise);
    end
    n_cmp++;
    if (c0_first !== 656) begin
      n_bad++;
      $display("FAIL line_hsync_start: got %0d want 656", c0_first);
    end
    n_cmp++;
    if (c0_low !== 96) begin
      n_bad++;
      $display("FAIL line_hsync_width: got %0d want 96", c0_low);
    end
    n_cmp++;
    if (ls_last - ls_prev !== 800 || ls_last !== 1600) begin
      n_bad++;
      $display("FAIL line_start_period: got %0d (last at %0d) want 800 (last at 1600)",
               ls_last - ls_prev, ls_last);
    end
    n_cmp++;
    if (xy_bad !== 0) begin
      n_bad++;
      $display("FAIL line_xy_track: got %0d bad samples want 0", xy_bad);
    end
  endtask

  task automatic test_frame();
    int fs_idx[$];
    int c1_first = -1;
    int c1_low   = 0;
    int vis      = 0;
    int ls_cnt   = 0;
    int y_bad    = 0;
    int v;
    start_run();
    for (int i = 0; i <= 6400; i++) begin
      v = i / 800;
      if (m_fs === 1'b1) fs_idx.push_back(i);
      if (i < 6400) begin
        if (m_c1 === 1'b0) begin
          c1_low++;
          if (c1_first < 0) c1_first = i;
        end
        if (m_blank === 1'b0) vis++;
        if (m_ls === 1'b1) ls_cnt++;
        if (m_y !== ((v < 4) ? 11'(v) : 11'd0)) y_bad++;
      end
      if (i < 6400) step_n(1);
    end
    n_cmp++;
    if (fs_idx.size() !== 2 || fs_idx[0] !== 0 || fs_idx[fs_idx.size()-1] !== 6400) begin
      n_bad++;
      $display("FAIL frame_start_period: got %0d pulses, last at %0d want 2 pulses at 0 and 6400",
               fs_idx.size(), (fs_idx.size() > 0) ? fs_idx[fs_idx.size()-1] : -1);
    end
    n_cmp++;
    if (c1_first !== 4000 || c1_low !== 1600) begin
      n_bad++;
      $display("FAIL frame_vsync: got start %0d width %0d want start 4000 width 1600", c1_first, c1_low);
    end
    n_cmp++;
    if (vis !== 2560) begin
      n_bad++;
      $display("FAIL frame_visible_count: got %0d want 2560", vis);
    end
    n_cmp++;
    if (ls_cnt !== 8) begin
      n_bad++;
      $display("FAIL frame_line_count: got %0d want 8", ls_cnt);
    end
    n_cmp++;
    if (y_bad !== 0) begin
      n_bad++;
      $display("FAIL frame_y_track: got %0d bad samples want 0", y_bad);
    end
  endtask

  // Pauses: edges 1..5 (holding pixel 0) and edges 306..342 (holding pixel 300), 42 in total.
  task automatic test_enable_hold();
    int hold_bad = 0;
    int c0_first = -1;
    int c0_low   = 0;
    int ls_next  = -1;
    start_run();
    for (int t = 0; t <= 850; t++) begin
      if (t >= 1 && t <= 5 && (d_ls !== 1'b0 || d_fs !== 1'b0 || d_x !== 11'd0 || d_blank !== 1'b0))
        hold_bad++;
      if (t >= 306 && t <= 342 && (d_x !== 11'd300 || d_ls !== 1'b0 || d_blank !== 1'b0 || d_c0 !== 1'b1))
        hold_bad++;
      if (t < 800 && d_c0 === 1'b0) begin
        c0_low++;
        if (c0_first < 0) c0_first = t;
      end
      if (t > 5 && d_ls === 1'b1 && ls_next < 0) ls_next = t;
      en = !((t >= 0 && t < 5) || (t >= 305 && t < 342));
      if (t < 850) step_n(1);
    end
    en = 1'b1;
    n_cmp++;
    if (hold_bad !== 0) begin
      n_bad++;
      $display("FAIL en_hold: got %0d bad paused samples want 0", hold_bad);
    end
    n_cmp++;
    if (c0_first !== 698 || c0_low !== 96) begin
      n_bad++;
      $display("FAIL en_hsync_shift: got start %0d width %0d want start 698 width 96", c0_first, c0_low);
    end
    n_cmp++;
    if (ls_next !== 842) begin
      n_bad++;
      $display("FAIL en_line_shift: got %0d want 842", ls_next);
    end
  endtask

  task automatic test_mid_frame_reset();
    start_run();
    step_n(4700);
    n_cmp++;
    if (m_c0 !== 1'b0 || m_c1 !== 1'b0 || m_blank !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre_sync: got c0=%b c1=%b blank=%b want 0 0 1", m_c0, m_c1, m_blank);
    end
    rst = 1'b1;
    step_n(1);
    n_cmp++;
    if ({m_blank, m_c0, m_c1, m_ls, m_fs} !== 5'b11100 || m_x !== 11'd0 || m_y !== 11'd0) begin
      n_bad++;
      $display("FAIL mid_reset_state: got b/c0/c1/ls/fs=%b x=%0d y=%0d want 11100 0 0",
               {m_blank, m_c0, m_c1, m_ls, m_fs}, m_x, m_y);
    end
    rst = 1'b0;
    step_n(1);
    n_cmp++;
    if ({m_blank, m_c0, m_c1, m_ls, m_fs} !== 5'b01111 || m_x !== 11'd0 || m_y !== 11'd0) begin
      n_bad++;
      $display("FAIL mid_restart: got b/c0/c1/ls/fs=%b x=%0d y=%0d want 01111 0 0",
               {m_blank, m_c0, m_c1, m_ls, m_fs}, m_x, m_y);
    end
    step_n(1);
    n_cmp++;
    if (m_x !== 11'd1 || m_ls !== 1'b0 || m_fs !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_restart_next: got x=%0d ls=%b fs=%b want 1 0 0", m_x, m_ls, m_fs);
    end
  endtask

  task automatic test_small_pos_pol();
    int c0_hi    = 0;
    int c0_first = -1;
    int c1_hi    = 0;
    int c1_first = -1;
    int vis      = 0;
    int fs_last  = -1;
    int fs_cnt   = 0;
    rst = 1'b1;
    en  = 1'b1;
    step_n(2);
    n_cmp++;
    if ({s_blank, s_c0, s_c1, s_ls, s_fs} !== 5'b10000 || s_x !== 11'd0 || s_y !== 11'd0) begin
      n_bad++;
      $display("FAIL small_reset: got b/c0/c1/ls/fs=%b x=%0d y=%0d want 10000 0 0",
               {s_blank, s_c0, s_c1, s_ls, s_fs}, s_x, s_y);
    end
    rst = 1'b0;
    step_n(1);
    for (int i = 0; i <= 48; i++) begin
      if (i < 8 && s_c0 === 1'b1) begin
        c0_hi++;
        if (c0_first < 0) c0_first = i;
      end
      if (i < 48) begin
        if (s_c1 === 1'b1) begin
          c1_hi++;
          if (c1_first < 0) c1_first = i;
        end
        if (s_blank === 1'b0) vis++;
      end
      if (s_fs === 1'b1) begin
        fs_cnt++;
        fs_last = i;
      end
      if (i < 48) step_n(1);
    end
    n_cmp++;
    if (c0_hi !== 2 || c0_first !== 5) begin
      n_bad++;
      $display("FAIL small_hsync: got %0d high from %0d want 2 high from 5", c0_hi, c0_first);
    end
    n_cmp++;
    if (c1_hi !== 8 || c1_first !== 32) begin
      n_bad++;
      $display("FAIL small_vsync: got %0d high from %0d want 8 high from 32", c1_hi, c1_first);
    end
    n_cmp++;
    if (fs_cnt !== 2 || fs_last !== 48) begin
      n_bad++;
      $display("FAIL small_frame_period: got %0d pulses last at %0d want 2 pulses last at 48", fs_cnt, fs_last);
    end
    n_cmp++;
    if (vis !== 12) begin
      n_bad++;
      $display("FAIL small_visible: got %0d want 12", vis);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_enable_hold();
    test_mid_frame_reset();
    test_small_pos_pol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
